// File: rtl/fp_term_fixed_stream_adapter.sv
// Converts IEEE-754 single terms to signed Q(OUT_W-FRAC_BITS).FRAC_BITS and queues them on a valid/ready stream.
// Optional FP2FIX_ROUND_EN: round half away from zero instead of truncating toward zero.
module fp_term_fixed_stream_adapter #(
  parameter int OUT_W     = 32,
  parameter int FRAC_BITS = 16,
  parameter int DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_enable,
  input  logic [31:0]              in_n,
  input  logic [31:0]              in_term,
  input  logic                     in_valid,
  input  logic                     in_done,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = OUT_W + 24;
  localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  // Returns {sat, data}; magnitude is built unsigned, then negated for negative inputs.
  function automatic logic [OUT_W:0] fp2fix(input logic [31:0] f);
    logic [7:0]       e;
    logic [23:0]      m;
    logic [WW-1:0]    mag;
    logic             big;
    logic             sat;
    logic [OUT_W-1:0] res;
    int               sh;
`ifdef FP2FIX_ROUND_EN
    logic [23:0]      rsh;
`endif
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    sh  = int'({24'd0, e}) - 150 + FRAC_BITS;
    mag = '0;
    big = 1'b0;
    if (e == 8'd0) begin
      return '0;
    end
    if (e == 8'hFF) begin
      return (f[31] && (f[22:0] == 23'd0)) ? {1'b1, MIN_NEG} : {1'b1, MAX_POS};
    end
    if (sh >= OUT_W) begin
      big = 1'b1;
    end else if (sh >= 0) begin
      mag = {{OUT_W{1'b0}}, m} << sh;
    end else if (sh > -25) begin
      mag = {{OUT_W{1'b0}}, m} >> (-sh);
`ifdef FP2FIX_ROUND_EN
      rsh = m >> (-sh - 1);
      mag = mag + WW'(rsh[0]);
`endif
    end
    sat = big || (mag[WW-1:OUT_W-1] != '0);
    if (sat) begin
      res = f[31] ? MIN_NEG : MAX_POS;
    end else begin
      res = f[31] ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
    end
    return {sat, res};
  endfunction

  logic signed [OUT_W-1:0] mem_data [DEPTH];
  logic                    mem_sat  [DEPTH];
  logic                    mem_last [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [31:0]             count_q, n_q;
  logic                    en_q, done_q;

  logic                    en_rise, done_rise, full, pop, push_ok, drop;
  logic [31:0]             n_eff, cnt_base, cnt_next;
  logic [32:0]             cnt_inc;
  logic signed [OUT_W-1:0] data_p0;
  logic                    sat_p0, last_p0, vld_p0;

  // Stage p0: combinational conversion, term numbering and FIFO handshake decode
  always_comb begin
    en_rise   = in_enable & ~en_q;
    done_rise = in_done & ~done_q;
    n_eff     = en_rise ? in_n : n_q;
    cnt_base  = en_rise ? 32'd0 : count_q;
    cnt_inc   = {1'b0, cnt_base} + 33'd1;
    cnt_next  = cnt_base;
    if (in_valid && !(&cnt_base)) cnt_next = cnt_inc[31:0];
    {sat_p0, data_p0} = fp2fix(in_term);
    last_p0   = (n_eff != 32'd0) && (cnt_inc == {1'b0, n_eff});
    vld_p0    = in_valid;
    full      = (level == LW'(DEPTH));
    pop       = out_valid & out_ready;
    push_ok   = vld_p0 & (~full | pop);
    drop      = vld_p0 & full & ~pop;
  end

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_sat   = out_valid & mem_sat[rd_ptr];
  assign out_last  = out_valid & mem_last[rd_ptr];

  // Stage p1: FIFO storage (data path, no reset)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= data_p0;
      mem_sat[wr_ptr]  <= sat_p0;
      mem_last[wr_ptr] <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      count_q  <= '0;
      n_q      <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      en_q     <= in_enable;
      done_q   <= in_done;
      n_q      <= n_eff;
      count_q  <= cnt_next;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level    <= level + LW'(push_ok) - LW'(pop);
      // A new sequence clears the sticky flags; an event in the same cycle still sets them.
      overflow <= (overflow & ~en_rise) | drop;
      len_err  <= (len_err & ~en_rise) | (done_rise && (cnt_base != n_eff));
    end
  end

endmodule

// File: tb/tb_fp_term_fixed_stream_adapter.sv
// Bench for fp_term_fixed_stream_adapter: directed scenarios then random traffic against a queue-based model.
module tb_fp_term_fixed_stream_adapter;
  localparam int OUT_W = 32, FRAC_BITS = 16, DEPTH = 8;

  logic clk = 1'b0;
  logic rst, in_enable, in_valid, in_done, out_ready;
  logic [31:0] in_n, in_term;
  logic signed [OUT_W-1:0] out_data;
  logic out_sat, out_last, out_valid, overflow, len_err;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  fp_term_fixed_stream_adapter #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .in_n(in_n), .in_term(in_term),
    .in_valid(in_valid), .in_done(in_done), .out_data(out_data), .out_sat(out_sat),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .overflow(overflow), .len_err(len_err));

  int total = 0, bad = 0;

  typedef struct packed {logic [31:0] d; logic s; logic l;} ent_t;
  ent_t        q[$];
  longint      m_count;
  logic [31:0] m_n;
  logic        m_ovf, m_lerr, m_en_prev, m_done_prev;

  // Value-level reference: mantissa * 2^k evaluated in real arithmetic.
  function automatic logic [32:0] ref_conv(input logic [31:0] f);
    logic [7:0] e;
    real        v;
    int         k;
    longint     mag;
    e = f[30:23];
    if (e == 8'd0) return 33'd0;
    if (e == 8'hFF) return (f[31] && f[22:0] == 23'd0) ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    k = int'(e) - 127 + FRAC_BITS;
    for (int i = 0; i < k; i++) v = v * 2.0;
    for (int i = 0; i < -k; i++) v = v / 2.0;
`ifdef FP2FIX_ROUND_EN
    v = $floor(v + 0.5);
`else
    v = $floor(v);
`endif
    if (v >= 2147483648.0) return f[31] ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
    mag = longint'(v);
    return {1'b0, f[31] ? 32'(-mag) : 32'(mag)};
  endfunction

  task automatic model_edge();
    logic  pop;
    ent_t  e;
    if (rst) begin
      q.delete();
      m_count = 0; m_n = 0; m_ovf = 0; m_lerr = 0; m_en_prev = 0; m_done_prev = 0;
      return;
    end
    pop = (q.size() != 0) && out_ready;
    if (in_enable && !m_en_prev) begin
      m_n = in_n; m_count = 0; m_ovf = 0; m_lerr = 0;
    end
    if (in_done && !m_done_prev && m_count != longint'(m_n)) m_lerr = 1;
    if (in_valid) begin
      e.l = (m_n != 0) && (m_count + 1 == longint'(m_n));
      {e.s, e.d} = ref_conv(in_term);
      if (m_count < 64'hFFFF_FFFF) m_count++;
      if (pop) void'(q.pop_front());
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1;
    end else if (pop) begin
      void'(q.pop_front());
    end
    m_en_prev = in_enable;
    m_done_prev = in_done;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("len_err", 32'(len_err), 32'(m_lerr));
    if (q.size() != 0) begin
      chk("out_data", $unsigned(out_data), q[0].d);
      chk("out_sat", 32'(out_sat), 32'(q[0].s));
      chk("out_last", 32'(out_last), 32'(q[0].l));
    end else begin
      chk("out_data_idle", $unsigned(out_data), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_term();
    logic [7:0] e;
    logic [22:0] mt;
    int r;
    r = int'($urandom_range(0, 9));
    mt = 23'($urandom);
    if (r == 0) e = 8'd0;
    else if (r == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) mt = '0; end
    else e = 8'(100 + $urandom_range(0, 45));
    return {1'($urandom), e, mt};
  endfunction

  logic [31:0] ints [12] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
  logic [31:0] dir_in  [7] = '{32'hBF000000, 32'h41200000, 32'h47C35000, 32'hC7C35000,
                               32'h7F800000, 32'h00000001, 32'h3DCCCCCD};
`ifdef FP2FIX_ROUND_EN
  logic [31:0] dir_out [7] = '{32'hFFFF8000, 32'h000A0000, 32'h7FFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'h00000000, 32'h0000199A};
`else
  logic [31:0] dir_out [7] = '{32'hFFFF8000, 32'h000A0000, 32'h7FFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'h00000000, 32'h00001999};
`endif
  logic        dir_sat [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] drain_exp [8] = '{32'h00020000, 32'h00030000, 32'h00040000, 32'h00050000,
                                 32'h00060000, 32'h00070000, 32'h00080000, 32'h000B0000};

  initial begin
    rst = 1; in_enable = 0; in_n = 0; in_term = 0; in_valid = 0; in_done = 0; out_ready = 1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", $unsigned(out_data), 32'd0);
    chk("rst_flags", {30'd0, overflow, len_err}, 32'd0);
    rst = 0;
    tick();

    // Sequence of three terms, first one arriving with the enable rise
    in_enable = 1; in_n = 3;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_term = ints[i];
      tick();
      chk("t1_data", $unsigned(out_data), 32'h00010000 * 32'(i + 1));
      chk("t1_last", 32'(out_last), 32'(i == 2));
    end
    in_valid = 0; in_done = 1;
    tick();
    chk("t1_len_err", 32'(len_err), 32'd0);
    in_done = 0;

    // Directed conversions
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_term = dir_in[i];
      tick();
      chk("conv_data", $unsigned(out_data), dir_out[i]);
      chk("conv_sat", 32'(out_sat), 32'(dir_sat[i]));
      in_valid = 0;
      tick();
    end

    // Fill with consumer stalled, then push+pop while full, then drain
    out_ready = 0; in_enable = 0;
    tick();
    in_enable = 1; in_n = 10;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_term = ints[i];
      tick();
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_head", $unsigned(out_data), 32'h00010000);
    in_term = ints[10]; out_ready = 1;
    tick();
    chk("pp_level", 32'(level), 32'd8);
    in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("drain", $unsigned(out_data), drain_exp[i]);
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Reset mid-sequence, then a short sequence with done
    in_enable = 0;
    tick();
    in_enable = 1; in_n = 5;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_term = ints[i];
      tick();
    end
    in_valid = 0; rst = 1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    rst = 0; in_enable = 0;
    tick();
    in_enable = 1; in_n = 3;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_term = ints[i];
      tick();
    end
    in_valid = 0; in_done = 1;
    tick();
    chk("len_err_set", 32'(len_err), 32'd1);
    in_done = 0;
    tick(); tick();
    chk("len_err_hold", 32'(len_err), 32'd1);
    in_enable = 0;
    tick();
    in_enable = 1;
    tick();
    chk("len_err_clr", 32'(len_err), 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom);
      in_term   = rand_term();
      out_ready = ($urandom_range(0, 3) != 0);
      in_done   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 30) == 0) begin
        in_enable = ~in_enable;
        in_n = 32'($urandom_range(0, 12));
      end
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
